seq_calc_core: RTL and testbench
================================

SEQ_CALC_CORE -- requirements
Module: seq_calc_core

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 4..16.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin an operation; sampled only when busy=0.
REQ-005 Port: op  input  3  opcode: 000 MUL, 001 ADD, 010 DIV, 011 SUB, 100 NOT, 101 AND, 110 OR, 111 XOR.
REQ-006 Port: a  input  WIDTH  operand A, unsigned.
REQ-007 Port: b  input  WIDTH  operand B, unsigned.
REQ-008 Port: busy  output  1  high while a MUL/DIV iteration is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; result, remainder and flags are valid in that cycle.
REQ-010 Port: result  output  2*WIDTH  registered result, held until the next done.
REQ-011 Port: remainder  output  WIDTH  DIV remainder; zero for all other ops.
REQ-012 Port: err  output  1  divide-by-zero flag for the last completed op.
REQ-013 Port: neg  output  1  SUB borrow flag (a<b) for the last completed op.

Function
REQ-014 FSM states: IDLE, MUL, DIV; busy=1 exactly in MUL and DIV.
REQ-015 Accept: edge with state=IDLE and start=1 latches op, a and b; the inputs are not used after that edge.
REQ-016 Start while busy=1 is ignored: no latch, no extra done, and the in-flight op is unaffected.
REQ-017 Single-cycle ops (ADD, SUB, NOT, AND, OR, XOR): result, flags and done are written on the accept edge; done is high for the following cycle; state stays IDLE.
REQ-018 ADD: result = zero-extended a+b with carry in bit WIDTH; upper bits zero.
REQ-019 SUB: result[WIDTH-1:0] = (a-b) mod 2^WIDTH; upper bits zero; neg=1 iff a<b.
REQ-020 NOT: result[WIDTH-1:0] = ~a; AND/OR/XOR: bitwise a op b in the low WIDTH bits; upper bits zero; b is ignored for NOT.
REQ-021 MUL: shift-add, one partial product per cycle; accept edge -> MUL; WIDTH iteration edges; the last iteration edge writes the full 2*WIDTH unsigned product, pulses done and returns to IDLE.
REQ-022 DIV: restoring division, one quotient bit per cycle; same timing as MUL; quotient in result[WIDTH-1:0], upper bits zero; remainder on remainder.
REQ-023 DIV with b=0: no iteration; on the accept edge result = all ones (2*WIDTH), remainder = a, err=1, done pulses the next cycle.
REQ-024 The err and neg outputs are recomputed at every done and are 0 unless the completing op sets them.
REQ-025 Latency from the accept edge to the done cycle: 1 cycle for single-cycle ops and DIV-by-zero; WIDTH+1 cycles for MUL and DIV.
REQ-026 Back-to-back: start=1 in the done cycle is accepted, because state is IDLE then.
REQ-027 Intermediate accumulator and counter values are never visible on result or remainder.
REQ-028 The done output is never high for two consecutive cycles from a single accept.

Reset
REQ-029 rst_n low asynchronously forces state IDLE, busy=0, done=0, result=0, remainder=0, err=0, neg=0, and clears the iteration counter and accumulators.
REQ-030 Reset during MUL/DIV aborts the op: no done after rst_n deasserts, and result stays 0.
REQ-031 The first accept is possible on the first rising edge at which rst_n is high.

Verification (WIDTH=8)
REQ-032 MUL a=13 b=11 -> busy for 8 cycles; done in cycle 9 after accept; result=143, err=0.
REQ-033 DIV a=200 b=7 -> done 9 cycles after accept; result=28, remainder=4; DIV a=5 b=0 -> done next cycle, result=0xFFFF, remainder=5, err=1.
REQ-034 SUB a=3 b=5 -> result=0x00FE, neg=1; ADD a=255 b=1 -> result=0x0100, neg=0; XOR a=3 b=1 -> result=2; NOT a=0x0F -> result=0x00F0.
REQ-035 MUL a=3 b=4 accepted, then start with ADD held during busy -> exactly one done, result=12; ADD accepted in the done cycle -> done on the next cycle.
REQ-036 rst_n pulsed low 3 cycles into MUL a=200 b=200 -> outputs 0 immediately; no done afterwards; a subsequent AND a=0xF0 b=0x3C -> result=0x30.

Source files
------------

// File: rtl/seq_calc_core.sv
// seq_calc_core: small sequential calculator.
// Single-cycle ADD/SUB/NOT/AND/OR/XOR, iterative shift-add MUL and
// restoring DIV (one bit per cycle). Results are registered and only
// published together with a one-cycle done pulse.
module seq_calc_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic               err,
  output logic               neg
);

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam int              CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic               accept;
  logic               last_iter;
  logic               div_by_zero;

  // Iteration registers: multiplicand/multiplier/product for MUL,
  // divisor/quotient/partial remainder for DIV.
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;
  logic [CNT_W-1:0]   count_q;

  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   div_low;
  logic               div_fits;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quot_next;

  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] alu_result;
  logic               alu_neg;

  // State register for the control FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: only IDLE accepts; MUL/DIV run until the last iteration.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    busy        = 1'b0;
    last_iter   = (count_q == LAST_ITER);
    div_by_zero = (b == '0);
    case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (op == OP_MUL) begin
            state_d = MUL;
          end else if (op == OP_DIV && !div_by_zero) begin
            state_d = DIV;
          end
        end
      end
      MUL, DIV: begin
        busy = 1'b1;
        if (last_iter) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle operations, evaluated directly from the live inputs.
  always_comb begin
    add_sum    = {1'b0, a} + {1'b0, b};
    alu_result = '0;
    alu_neg    = 1'b0;
    case (op)
      OP_ADD: alu_result = {{(WIDTH-1){1'b0}}, add_sum};
      OP_SUB: begin
        alu_result = {{WIDTH{1'b0}}, a - b};
        alu_neg    = (a < b);
      end
      OP_NOT: alu_result = {{WIDTH{1'b0}}, ~a};
      OP_AND: alu_result = {{WIDTH{1'b0}}, a & b};
      OP_OR:  alu_result = {{WIDTH{1'b0}}, a | b};
      OP_XOR: alu_result = {{WIDTH{1'b0}}, a ^ b};
      default: alu_result = '0;
    endcase
  end

  // One iteration step of each algorithm. For DIV the shifted partial
  // remainder is WIDTH+1 bits; its top bit is rem_q's MSB, which forces a
  // subtract, and the WIDTH-bit difference is exact in that case.
  always_comb begin
    prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
    div_low   = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
    div_fits  = rem_q[WIDTH-1] | (div_low >= divisor_q);
    rem_next  = div_fits ? (div_low - divisor_q) : div_low;
    quot_next = {quot_q[WIDTH-2:0], div_fits};
  end

  // Datapath: latch operands on accept, iterate, publish on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      done      <= 1'b0;
      result    <= '0;
      remainder <= '0;
      err       <= 1'b0;
      neg       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        case (op)
          OP_MUL: begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            prod_q   <= '0;
            count_q  <= '0;
          end
          OP_DIV: begin
            if (div_by_zero) begin
              result    <= '1;
              remainder <= a;
              err       <= 1'b1;
              neg       <= 1'b0;
              done      <= 1'b1;
            end else begin
              divisor_q <= b;
              quot_q    <= a;
              rem_q     <= '0;
              count_q   <= '0;
            end
          end
          default: begin
            result    <= alu_result;
            remainder <= '0;
            err       <= 1'b0;
            neg       <= alu_neg;
            done      <= 1'b1;
          end
        endcase
      end else if (state_q == MUL) begin
        prod_q   <= prod_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        count_q  <= count_q + CNT_W'(1);
        if (last_iter) begin
          result    <= prod_next;
          remainder <= '0;
          err       <= 1'b0;
          neg       <= 1'b0;
          done      <= 1'b1;
        end
      end else if (state_q == DIV) begin
        quot_q  <= quot_next;
        rem_q   <= rem_next;
        count_q <= count_q + CNT_W'(1);
        if (last_iter) begin
          result    <= {{WIDTH{1'b0}}, quot_next};
          remainder <= rem_next;
          err       <= 1'b0;
          neg       <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_calc_core.sv
// tb_seq_calc_core: table-driven vectors, hand-written multi-cycle
// sequences and random operations against an arithmetic reference model.
module tb_seq_calc_core;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   remainder;
  logic               err;
  logic               neg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int op;
    int a;
    int b;
    int res;
    int rem;
    int err;
    int neg;
    int lat;
  } vec_t;

  vec_t vecs[13];

  seq_calc_core #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .remainder (remainder),
    .err       (err),
    .neg       (neg)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Safety net in case done never arrives somewhere unbounded.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Called at a negedge; presents one request for exactly one rising edge.
  task automatic applyStimulus(input int o, input int x, input int y);
    op    = 3'(o);
    a     = WIDTH'(x);
    b     = WIDTH'(y);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done, reporting its latency in cycles after the accept edge.
  task automatic waitDone(output int lat, output int busy_cycles, output int stable);
    logic [2*WIDTH-1:0] held;
    held        = result;
    lat         = 0;
    busy_cycles = 0;
    stable      = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cycles++;
      if (result !== held) stable = 0;
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  // Reference behaviour from plain arithmetic on the operand values.
  function automatic void refModel(input int o, input int x, input int y,
                                   output int res, output int rem, output int e,
                                   output int n, output int lat);
    res = 0; rem = 0; e = 0; n = 0; lat = 1;
    case (o)
      0: begin res = x * y; lat = WIDTH + 1; end
      1: res = x + y;
      2: begin
        if (y == 0) begin
          res = (1 << (2 * WIDTH)) - 1;
          rem = x;
          e   = 1;
        end else begin
          res = x / y;
          rem = x % y;
          lat = WIDTH + 1;
        end
      end
      3: begin
        res = (x - y + (1 << WIDTH)) % (1 << WIDTH);
        n   = (x < y) ? 1 : 0;
      end
      4: res = ((1 << WIDTH) - 1) - x;
      5: res = x & y;
      6: res = x | y;
      default: res = x ^ y;
    endcase
  endfunction

  task automatic runAndCheck(input string tag, input int o, input int x, input int y,
                             input int e_res, input int e_rem, input int e_err,
                             input int e_neg, input int e_lat);
    int lat, busy_cycles, stable;
    applyStimulus(o, x, y);
    waitDone(lat, busy_cycles, stable);
    checkOutput({tag, "_latency"}, lat, e_lat);
    checkOutput({tag, "_busy_cycles"}, busy_cycles, e_lat - 1);
    checkOutput({tag, "_result_stable"}, stable, 1);
    checkOutput({tag, "_busy_at_done"}, busy, 0);
    checkOutput({tag, "_result"}, result, e_res);
    checkOutput({tag, "_remainder"}, remainder, e_rem);
    checkOutput({tag, "_err"}, err, e_err);
    checkOutput({tag, "_neg"}, neg, e_neg);
    @(negedge clk);
    checkOutput({tag, "_done_single"}, done, 0);
  endtask

  initial begin
    int r_res, r_rem, r_err, r_neg, r_lat;
    int o, x, y, dones, nonzero, lat;

    vecs[0]  = '{3, 3, 5, 'h00FE, 0, 0, 1, 1};
    vecs[1]  = '{1, 255, 1, 'h0100, 0, 0, 0, 1};
    vecs[2]  = '{7, 3, 1, 2, 0, 0, 0, 1};
    vecs[3]  = '{4, 'h0F, 'hAA, 'h00F0, 0, 0, 0, 1};
    vecs[4]  = '{5, 'hF0, 'h3C, 'h30, 0, 0, 0, 1};
    vecs[5]  = '{6, 'hF0, 'h0F, 'hFF, 0, 0, 0, 1};
    vecs[6]  = '{3, 9, 9, 0, 0, 0, 0, 1};
    vecs[7]  = '{0, 13, 11, 143, 0, 0, 0, 9};
    vecs[8]  = '{0, 255, 255, 65025, 0, 0, 0, 9};
    vecs[9]  = '{2, 200, 7, 28, 4, 0, 0, 9};
    vecs[10] = '{2, 5, 0, 'hFFFF, 5, 1, 0, 1};
    vecs[11] = '{1, 0, 0, 0, 0, 0, 0, 1};
    vecs[12] = '{2, 7, 200, 0, 7, 0, 0, 9};

    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_neg", neg, 0);
    rst_n = 1'b1;

    // First request goes out on the very first edge with reset released.
    for (int i = 0; i < 13; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].rem, vecs[i].err, vecs[i].neg, vecs[i].lat);
    end

    // MUL 3*4 with an ADD request held high throughout the busy period.
    op = 3'b000; a = 8'd3; b = 8'd4; start = 1'b1;
    @(posedge clk);
    #1 op = 3'b001; a = 8'd1; b = 8'd2;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    checkOutput("hold_mul_latency", lat, 9);
    checkOutput("hold_mul_result", result, 12);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_add_done", done, 1);
    checkOutput("b2b_add_result", result, 3);
    @(negedge clk);
    checkOutput("b2b_add_done_single", done, 0);

    // Reset three cycles into MUL 200*200 aborts it.
    applyStimulus(0, 200, 200);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_result", result, 0);
    checkOutput("abort_remainder", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones   = 0;
    nonzero = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (result != '0) nonzero++;
    end
    checkOutput("abort_no_done", dones, 0);
    checkOutput("abort_result_held", nonzero, 0);
    runAndCheck("after_abort_and", 5, 'hF0, 'h3C, 'h30, 0, 0, 0, 1);

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      o = int'($urandom_range(0, 7));
      x = int'($urandom_range(0, 255));
      y = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
      refModel(o, x, y, r_res, r_rem, r_err, r_neg, r_lat);
      runAndCheck($sformatf("rnd%0d_op%0d_%0d_%0d", i, o, x, y), o, x, y,
                  r_res, r_rem, r_err, r_neg, r_lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
